sram_2p_march_bist: RTL and testbench

March C- built-in self-test controller for one port of the dual-port SRAM macro. It drives the port's MEN/ADDR/DIN/BM/WEN/REN pins and checks the port's registered read data against expected values. It reports pass/fail, the first failing address, element and bits, and a saturating error count. It sits in front of the BIST mux on the SRAM A or B port; the other port must stay idle (MEN=0) while BUSY is high.

---
 rtl/sram_2p_march_bist.sv | 154 +++++++++++++++
 tb/tb_sram_2p_march_bist.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_2p_march_bist.sv
// March C- self-test for one SRAM port: 10N op cycles, one drain cycle, then DONE.
// Latency: read data is compared two edges after the read is driven; no backpressure (one op per clock).
module sram_2p_march_bist #(
   parameter int P_DATA_WIDTH   = 20,
   parameter int P_ADDR_WIDTH   = 9,
   parameter int P_ERRCNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      fail,
   output logic [P_ADDR_WIDTH-1:0]   fail_addr,
   output logic [2:0]                fail_elem,
   output logic [P_DATA_WIDTH-1:0]   fail_bits,
   output logic [P_ERRCNT_WIDTH-1:0] err_cnt,
   output logic                      mem_men,
   output logic                      mem_wen,
   output logic                      mem_ren,
   output logic [P_ADDR_WIDTH-1:0]   mem_addr,
   output logic [P_DATA_WIDTH-1:0]   mem_din,
   output logic [P_DATA_WIDTH-1:0]   mem_bm,
   input  logic [P_DATA_WIDTH-1:0]   mem_dout
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [P_ADDR_WIDTH-1:0]   ADDR_ONE = 1;
   localparam logic [P_ERRCNT_WIDTH-1:0] CNT_ONE  = 1;

   state_t                    state_q, state_d;
   logic [2:0]                elem_q, elem_d;
   logic [P_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                      ph_q, ph_d;
   logic                      issue, clr, op_rd, two_op, down_q, last_addr, last_op, run_nxt;
   logic                      cmp_vld, cmp_exp;
   logic [P_ADDR_WIDTH-1:0]   cmp_addr;
   logic [2:0]                cmp_elem;
   logic [P_DATA_WIDTH-1:0]   diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // elem/addr/ph describe the op currently on the MEM_* registers; *_d is the op issued next
   always_comb begin
      state_d   = state_q;
      elem_d    = elem_q;
      addr_d    = addr_q;
      ph_d      = ph_q;
      issue     = 1'b0;
      clr       = 1'b0;
      two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
      down_q    = (elem_q == 3'd3) || (elem_q == 3'd4);
      last_addr = down_q ? (addr_q == '0) : (addr_q == '1);
      last_op   = (elem_q == 3'd5) && last_addr;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               addr_d  = '0;
               ph_d    = 1'b0;
               issue   = 1'b1;
               clr     = 1'b1;
            end
         end
         S_RUN: begin
            if (last_op) begin
               state_d = S_DRAIN;
            end else begin
               issue = 1'b1;
               if (two_op && !ph_q) begin
                  ph_d = 1'b1;
               end else begin
                  ph_d = 1'b0;
                  if (last_addr) begin
                     elem_d = elem_q + 3'd1;
                     addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
                  end else begin
                     addr_d = down_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                  end
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      op_rd   = (elem_d == 3'd5) || ((elem_d != 3'd0) && !ph_d);
      run_nxt = (state_d == S_RUN) || (state_d == S_DRAIN);
   end

   assign diff = mem_dout ^ {P_DATA_WIDTH{cmp_exp}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_q    <= '0;
         addr_q    <= '0;
         ph_q      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_bits <= '0;
         err_cnt   <= '0;
         mem_men   <= 1'b0;
         mem_wen   <= 1'b0;
         mem_ren   <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         mem_bm    <= '0;
         cmp_vld   <= 1'b0;
         cmp_exp   <= 1'b0;
         cmp_addr  <= '0;
         cmp_elem  <= '0;
      end else begin
         elem_q   <= elem_d;
         addr_q   <= addr_d;
         ph_q     <= ph_d;
         busy     <= run_nxt;
         done     <= (state_d == S_DONE);
         mem_bm   <= run_nxt ? '1 : '0;
         mem_men  <= issue;
         mem_ren  <= issue && op_rd;
         mem_wen  <= issue && !op_rd;
         mem_addr <= issue ? addr_d : '0;
         mem_din  <= (issue && !op_rd && elem_d[0]) ? '1 : '0;
         // the macro samples the read on this edge; its data is checked on the next one
         cmp_vld  <= mem_ren;
         cmp_exp  <= (elem_q == 3'd2) || (elem_q == 3'd4);
         cmp_addr <= mem_addr;
         cmp_elem <= elem_q;
         if (clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_bits <= '0;
            err_cnt   <= '0;
         end else if (cmp_vld && (|diff)) begin
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
            if (!fail) begin
               fail      <= 1'b1;
               fail_addr <= cmp_addr;
               fail_elem <= cmp_elem;
               fail_bits <= diff;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// Bench: behavioral SRAM with injectable stuck-at faults, march op scoreboard, result vectors.
module tb_sram_2p_march_bist;
   localparam int DW   = 20;
   localparam int AW   = 4;
   localparam int CW   = 3;
   localparam int N    = 16;
   localparam int NOPS = 10 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_bits;
   logic [CW-1:0] err_cnt;
   logic          mem_men, mem_wen, mem_ren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_bm, mem_dout;

   always #5 clk = ~clk;

   sram_2p_march_bist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_ERRCNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bits(fail_bits), .err_cnt(err_cnt),
      .mem_men(mem_men), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_bm(mem_bm), .mem_dout(mem_dout)
   );

   typedef struct packed {
      logic          busy, men, wen, ren;
      logic [AW-1:0] addr;
      logic [DW-1:0] din, bm;
   } op_t;

   typedef struct {
      int            fault;
      logic          fail;
      logic [AW-1:0] faddr;
      logic [2:0]    felem;
      logic [DW-1:0] fbits;
      logic [CW-1:0] cnt;
   } vec_t;

   op_t           exp_q[$];
   vec_t          vecs[4];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            fault = 0;
   logic          scramble = 1'b0;
   logic [DW-1:0] mem [N];

   // fault 1: addr 5 bit 3 stuck-at-1; fault 2: bit 0 stuck-at-0 everywhere
   function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input logic [AW-1:0] a);
      logic [DW-1:0] r;
      r = v;
      if (fault == 1 && a == 4'd5) r[3] = 1'b1;
      if (fault == 2) r[0] = 1'b0;
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (scramble) begin
         for (int i = 0; i < N; i++) mem[i] <= DW'($urandom);
      end else if (mem_men && mem_wen) begin
         mem[mem_addr] <= (mem_din & mem_bm) | (mem[mem_addr] & ~mem_bm);
      end
      if (mem_men && mem_ren) mem_dout <= rd_fault(mem[mem_addr], mem_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_op(input logic wr, input int a, input logic [DW-1:0] din);
      op_t o;
      o.busy = 1'b1;
      o.men  = 1'b1;
      o.wen  = wr;
      o.ren  = !wr;
      o.addr = AW'(a);
      o.din  = din;
      o.bm   = '1;
      exp_q.push_back(o);
   endtask

   task automatic push_march();
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < N; k++) begin
            int a;
            a = (e == 3 || e == 4) ? (N - 1 - k) : k;
            if (e >= 1) push_op(1'b0, a, '0);
            if (e <= 4) push_op(1'b1, a, (e % 2 == 1) ? '1 : '0);
         end
      end
   endtask

   task automatic run_march(input int abort_at, input int repulse_at);
      int  e0;
      op_t act;
      e0 = 0;
      exp_q.delete();
      push_march();
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < NOPS; i++) begin
         @(negedge clk);
         start = (i == repulse_at);
         if (i == 0) begin
            e0 = cyc;
            check("clr_at_start", {fail, fail_addr, fail_elem, fail_bits, err_cnt, done}, 64'd0);
         end
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_status", {busy, done, fail, fail_addr, fail_elem, fail_bits, err_cnt}, 64'd0);
            check("abort_mem", {mem_men, mem_wen, mem_ren, mem_addr, mem_din, mem_bm}, 64'd0);
            start = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            exp_q.delete();
            return;
         end
         act.busy = busy;
         act.men  = mem_men;
         act.wen  = mem_wen;
         act.ren  = mem_ren;
         act.addr = mem_addr;
         act.din  = mem_din;
         act.bm   = mem_bm;
         check($sformatf("op%0d", i), act, exp_q.pop_front());
      end
      start = 1'b0;
      @(negedge clk);
      check("drain", {busy, done, mem_men, mem_wen, mem_ren}, 64'b10000);
      @(negedge clk);
      check("done_flags", {busy, done, mem_men, mem_bm}, {41'd0, 1'b0, 1'b1, 1'b0, 20'h0});
      check("done_cycle", 64'(cyc - e0), 64'd161);
   endtask

   task automatic check_results(input vec_t v, input string tag);
      logic [DW-1:0] acc;
      acc = '0;
      check({tag, "_fail"}, 64'(fail), 64'(v.fail));
      check({tag, "_faddr"}, 64'(fail_addr), 64'(v.faddr));
      check({tag, "_felem"}, 64'(fail_elem), 64'(v.felem));
      check({tag, "_fbits"}, 64'(fail_bits), 64'(v.fbits));
      check({tag, "_errcnt"}, 64'(err_cnt), 64'(v.cnt));
      for (int i = 0; i < N; i++) acc = acc | mem[i];
      check({tag, "_mem_zero"}, 64'(acc), 64'd0);
   endtask

   task automatic scramble_mem();
      @(negedge clk);
      scramble = 1'b1;
      @(negedge clk);
      scramble = 1'b0;
   endtask

   initial begin
      vecs[0] = '{fault: 0, fail: 1'b0, faddr: 4'd0, felem: 3'd0, fbits: 20'h0,     cnt: 3'd0};
      vecs[1] = '{fault: 1, fail: 1'b1, faddr: 4'd5, felem: 3'd1, fbits: 20'h00008, cnt: 3'd3};
      vecs[2] = '{fault: 2, fail: 1'b1, faddr: 4'd0, felem: 3'd2, fbits: 20'h00001, cnt: 3'd7};
      vecs[3] = '{fault: 0, fail: 1'b0, faddr: 4'd0, felem: 3'd0, fbits: 20'h0,     cnt: 3'd0};

      #23;
      check("rst_status", {busy, done, fail, fail_addr, fail_elem, fail_bits, err_cnt}, 64'd0);
      check("rst_mem", {mem_men, mem_wen, mem_ren, mem_addr, mem_din, mem_bm}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle", {busy, done, mem_men}, 64'd0);

      for (int v = 0; v < 4; v++) begin
         fault = vecs[v].fault;
         scramble_mem();
         run_march(-1, -1);
         check_results(vecs[v], $sformatf("vec%0d", v));
      end

      fault = 0;
      scramble_mem();
      run_march(40, -1);
      repeat (2) @(negedge clk);
      check("post_abort_idle", {busy, done, mem_men}, 64'd0);
      scramble_mem();
      run_march(-1, -1);
      check_results(vecs[0], "after_abort");

      scramble_mem();
      run_march(-1, 20);
      check_results(vecs[0], "repulse");
      repeat (3) @(negedge clk);
      check("done_sticky", {busy, done}, 64'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
